// File: rtl/tb_pontos_if.sv
// +--------------------------------------------------------------------+
// | tb_pontos_if : operand/result bundle for the tb_pontos FP adder     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface tb_pontos_if;
  logic [31:0] Op_A_in;
  logic [31:0] Op_B_in;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  modport master (
    output Op_A_in,
    output Op_B_in,
    input  data_out,
    input  status_out
  );

  modport slave (
    input  Op_A_in,
    input  Op_B_in,
    output data_out,
    output status_out
  );
endinterface

`default_nettype wire

// File: rtl/tb_pontos.sv
// +--------------------------------------------------------------------+
// | tb_pontos : multi-cycle 32-bit custom-format floating-point adder   |
// | (s, e[5:0] bias 31, m[24:0]); PONTOS_ROUND_NEAREST_EN selects RNE   |
// | rounding, otherwise truncation.                  Rev 1.0            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_pontos (
  input  wire logic  clock_100kHz,
  input  wire logic  reset,
  tb_pontos_if.slave bus
);

  localparam logic [2:0] ST_LOAD  = 3'd0;
  localparam logic [2:0] ST_ALIGN = 3'd1;
  localparam logic [2:0] ST_ADD   = 3'd2;
  localparam logic [2:0] ST_NORM  = 3'd3;
  localparam logic [2:0] ST_ROUND = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic [5:0]  MAX_SHIFT = 6'd27;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  logic [2:0] r_state;
  logic [2:0] w_state_next;
  logic       w_en_load, w_en_align, w_en_add, w_en_norm, w_en_round, w_en_done;

  // Operand x always holds the larger exponent; y is the one aligned to it.
  logic               r_sign_x, r_sign_y;
  logic [5:0]         r_exp_x, r_exp_y;
  logic [27:0]        r_man_x, r_man_y;
  logic               r_sticky;
  logic               r_special, r_special_sign;
  logic [29:0]        r_sum;
  logic               r_sign;
  logic signed [7:0]  r_exp_r;
  logic [24:0]        r_res_man;
  logic signed [7:0]  r_res_exp;
  logic               r_inexact, r_zero;

  logic        w_a_zero, w_b_zero, w_swap, w_a_res, w_b_res;
  logic [5:0]  w_ea, w_eb, w_diff;
  logic [27:0] w_ma, w_mb;
  logic [29:0] w_xv, w_yv, w_add_sum;
  logic        w_add_sign, w_round_up;
  logic [25:0] w_rounded;
  logic [31:0] w_data_res;
  logic [3:0]  w_status_res;

  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) r_state <= ST_LOAD;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_LOAD:  w_state_next = ST_ALIGN;
      ST_ALIGN: if (w_diff == 6'd0) w_state_next = ST_ADD;
      ST_ADD:   w_state_next = ST_NORM;
      ST_NORM:  if ((r_sum == 30'd0) || r_sum[29] || r_sum[28]) w_state_next = ST_ROUND;
      ST_ROUND: w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_LOAD;
      default:  w_state_next = ST_LOAD;
    endcase
  end

  always_comb begin
    w_en_load  = (r_state == ST_LOAD);
    w_en_align = (r_state == ST_ALIGN);
    w_en_add   = (r_state == ST_ADD);
    w_en_norm  = (r_state == ST_NORM);
    w_en_round = (r_state == ST_ROUND);
    w_en_done  = (r_state == ST_DONE);
  end

  // A zero operand borrows the other exponent so it needs no alignment cycles.
  always_comb begin
    w_a_zero = (bus.Op_A_in[30:25] == 6'd0);
    w_b_zero = (bus.Op_B_in[30:25] == 6'd0);
    w_a_res  = (bus.Op_A_in[30:25] == 6'd63);
    w_b_res  = (bus.Op_B_in[30:25] == 6'd63);
    w_ea     = (w_a_zero && !w_b_zero) ? bus.Op_B_in[30:25] : bus.Op_A_in[30:25];
    w_eb     = (w_b_zero && !w_a_zero) ? bus.Op_A_in[30:25] : bus.Op_B_in[30:25];
    w_ma     = w_a_zero ? 28'd0 : {1'b1, bus.Op_A_in[24:0], 2'b00};
    w_mb     = w_b_zero ? 28'd0 : {1'b1, bus.Op_B_in[24:0], 2'b00};
    w_swap   = (w_eb > w_ea);
  end

  always_comb begin
    w_diff = r_exp_x - r_exp_y;
    w_xv   = {1'b0, r_man_x, 1'b0};
    w_yv   = {1'b0, r_man_y, r_sticky};
    if (r_sign_x == r_sign_y) begin
      w_add_sum  = w_xv + w_yv;
      w_add_sign = r_sign_x;
    end else if (w_xv >= w_yv) begin
      w_add_sum  = w_xv - w_yv;
      w_add_sign = r_sign_x;
    end else begin
      w_add_sum  = w_yv - w_xv;
      w_add_sign = r_sign_y;
    end
  end

  // After NORM: hidden = r_sum[28], mantissa = r_sum[27:3], G/R/S = r_sum[2:0].
  always_comb begin
`ifdef PONTOS_ROUND_NEAREST_EN
    w_round_up = r_sum[2] & (r_sum[1] | r_sum[0] | r_sum[3]);
`else
    w_round_up = 1'b0;
`endif
    w_rounded = {1'b0, r_sum[27:3]} + {25'd0, w_round_up};
  end

  always_comb begin
    w_data_res   = {r_sign, r_res_exp[5:0], r_res_man};
    w_status_res = r_inexact ? 4'b0001 : 4'b1000;
    if (r_special) begin
      w_data_res   = {r_special_sign, 6'd62, {25{1'b1}}};
      w_status_res = 4'b0101;
    end else if (r_zero) begin
      w_data_res   = ZERO_WORD;
      w_status_res = 4'b1000;
    end else if (r_res_exp > 8'sd62) begin
      w_data_res   = {r_sign, 6'd62, {25{1'b1}}};
      w_status_res = 4'b0101;
    end else if (r_res_exp < 8'sd1) begin
      w_data_res   = {r_sign, 31'd0};
      w_status_res = 4'b0011;
    end
  end

  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) begin
      r_sign_x       <= 1'b0;
      r_sign_y       <= 1'b0;
      r_exp_x        <= 6'd0;
      r_exp_y        <= 6'd0;
      r_man_x        <= 28'd0;
      r_man_y        <= 28'd0;
      r_sticky       <= 1'b0;
      r_special      <= 1'b0;
      r_special_sign <= 1'b0;
      r_sum          <= 30'd0;
      r_sign         <= 1'b0;
      r_exp_r        <= 8'sd0;
      r_res_man      <= 25'd0;
      r_res_exp      <= 8'sd0;
      r_inexact      <= 1'b0;
      r_zero         <= 1'b0;
      bus.data_out   <= ZERO_WORD;
      bus.status_out <= 4'b0000;
    end else begin
      if (w_en_load) begin
        r_sign_x       <= w_swap ? bus.Op_B_in[31] : bus.Op_A_in[31];
        r_sign_y       <= w_swap ? bus.Op_A_in[31] : bus.Op_B_in[31];
        r_exp_x        <= w_swap ? w_eb : w_ea;
        r_exp_y        <= w_swap ? w_ea : w_eb;
        r_man_x        <= w_swap ? w_mb : w_ma;
        r_man_y        <= w_swap ? w_ma : w_mb;
        r_sticky       <= 1'b0;
        r_special      <= w_a_res | w_b_res;
        r_special_sign <= w_a_res ? bus.Op_A_in[31] : bus.Op_B_in[31];
      end
      if (w_en_align && (w_diff != 6'd0)) begin
        if (w_diff > MAX_SHIFT) begin
          r_man_y  <= 28'd0;
          r_sticky <= r_sticky | (|r_man_y);
          r_exp_y  <= r_exp_x;
        end else begin
          r_man_y  <= {1'b0, r_man_y[27:1]};
          r_sticky <= r_sticky | r_man_y[0];
          r_exp_y  <= r_exp_y + 6'd1;
        end
      end
      if (w_en_add) begin
        r_sum   <= w_add_sum;
        r_sign  <= w_add_sign;
        r_exp_r <= $signed({2'b00, r_exp_x});
      end
      if (w_en_norm) begin
        if (r_sum[29]) begin
          r_sum   <= {1'b0, r_sum[29:2], r_sum[1] | r_sum[0]};
          r_exp_r <= r_exp_r + 8'sd1;
        end else if (!r_sum[28] && (r_sum != 30'd0)) begin
          r_sum   <= {r_sum[28:0], 1'b0};
          r_exp_r <= r_exp_r - 8'sd1;
        end
      end
      if (w_en_round) begin
        r_res_man <= w_rounded[24:0];
        r_res_exp <= r_exp_r + (w_rounded[25] ? 8'sd1 : 8'sd0);
        r_inexact <= |r_sum[2:0];
        r_zero    <= (r_sum == 30'd0);
      end
      if (w_en_done) begin
        bus.data_out   <= w_data_res;
        bus.status_out <= w_status_res;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tb_pontos.sv
// Self-checking bench for tb_pontos: directed corner cases plus random
// operands compared against an exact-arithmetic reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_tb_pontos;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   failed;

  tb_pontos_if bus ();

  tb_pontos u_dut (
    .clock_100kHz (clk),
    .reset        (rst_n),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact sum as a wide integer (value = X * 2^-55), then rounded and classified.
  function automatic logic [35:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [127:0]        ua, ub, mag, rem, half;
    logic signed [127:0] x;
    logic [26:0]         sig;
    int                  p, e;
    logic                s;
    if (a[30:25] == 6'd63) return {4'b0101, a[31], 6'd62, 25'h1FFFFFF};
    if (b[30:25] == 6'd63) return {4'b0101, b[31], 6'd62, 25'h1FFFFFF};
    ua = (a[30:25] == 6'd0) ? 128'd0 : (128'({1'b1, a[24:0]}) << (a[30:25] - 6'd1));
    ub = (b[30:25] == 6'd0) ? 128'd0 : (128'({1'b1, b[24:0]}) << (b[30:25] - 6'd1));
    x = (a[31] ? -$signed(ua) : $signed(ua)) + (b[31] ? -$signed(ub) : $signed(ub));
    if (x == 0) return {4'b1000, 32'h0};
    s   = x[127];
    mag = s ? -x : x;
    p   = 0;
    for (int i = 0; i < 128; i++) if (mag[i]) p = i;
    e    = p - 24;
    rem  = 128'd0;
    half = 128'd0;
    if (p > 25) begin
      sig  = 27'(mag >> (p - 25));
      rem  = mag & ((128'd1 << (p - 25)) - 128'd1);
      half = 128'd1 << (p - 26);
    end else begin
      sig = 27'(mag << (25 - p));
    end
`ifdef PONTOS_ROUND_NEAREST_EN
    if ((rem > half) || ((rem == half) && (rem != 0) && sig[0])) begin
      sig = sig + 27'd1;
      if (sig[26]) begin
        sig = sig >> 1;
        e   = e + 1;
      end
    end
`endif
    if (e > 62) return {4'b0101, s, 6'd62, 25'h1FFFFFF};
    if (e < 1)  return {4'b0011, s, 31'd0};
    return {(rem != 0) ? 4'b0001 : 4'b1000, s, 6'(e), sig[24:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reset, hold operands long enough for any operation to finish, then compare.
  task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_d, input logic [3:0] exp_s);
    @(negedge clk);
    bus.Op_A_in = a;
    bus.Op_B_in = b;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check({tag, "_data"}, bus.data_out, exp_d);
    check({tag, "_status"}, {28'd0, bus.status_out}, {28'd0, exp_s});
  endtask

  initial begin
    logic [35:0] r;
    logic [31:0] a, b;
    int          ea, eb;
    int          n;

    tests_run   = 0;
    failed      = 0;
    rst_n       = 1'b0;
    bus.Op_A_in = 32'h0;
    bus.Op_B_in = 32'h0;
    #1;
    check("reset_data", bus.data_out, 32'h0);
    check("reset_status", {28'd0, bus.status_out}, 32'h0);

    // 1.0 + 2.0: one alignment shift, result appears on the 7th edge after release
    @(negedge clk);
    bus.Op_A_in = 32'h3E000000;
    bus.Op_B_in = 32'h40000000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("lat_early", bus.data_out, 32'h0);
    @(posedge clk);
    #1;
    check("lat_data", bus.data_out, 32'h41000000);
    check("lat_status", {28'd0, bus.status_out}, 32'h8);

    run_check("cancel", 32'h3E000000, 32'hBE000000, 32'h00000000, 4'b1000);
    run_check("ovf_max", 32'h7DFFFFFF, 32'h7DFFFFFF, 32'h7DFFFFFF, 4'b0101);
    run_check("zero_b", 32'h3E000000, 32'h00000001, 32'h3E000000, 4'b1000);
`ifdef PONTOS_ROUND_NEAREST_EN
    run_check("big_gap", 32'h3E000000, 32'h0A000001, 32'h3E000001, 4'b0001);
`else
    run_check("big_gap", 32'h3E000000, 32'h0A000001, 32'h3E000000, 4'b0001);
`endif
    run_check("resv_exp", 32'hFE000000, 32'h3E000000, 32'hFDFFFFFF, 4'b0101);
    run_check("underflow", 32'h82000003, 32'h02000001, 32'h80000000, 4'b0011);

    // Reset pulsed while the FSM is aligning a 19-bit exponent gap
    run_check("pre_gap", 32'h3E000000, 32'h40000000, 32'h41000000, 4'b1000);
    @(negedge clk);
    bus.Op_A_in = 32'h3E000000;
    bus.Op_B_in = 32'h18000000;
    n = 0;
    while ((bus.data_out !== 32'h3E000040) && (n < 40)) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("gap_first", bus.data_out, 32'h3E000040);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_data", bus.data_out, 32'h0);
    check("midrst_status", {28'd0, bus.status_out}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("postrst_data", bus.data_out, 32'h3E000040);
    check("postrst_status", {28'd0, bus.status_out}, 32'h8);

    for (int t = 0; t < 60; t++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: ;
        1: begin
          ea = int'(a[30:25]);
          eb = ea + int'($urandom_range(0, 6)) - 3;
          if (eb < 0)  eb = 0;
          if (eb > 63) eb = 63;
          b[30:25] = 6'(eb);
        end
        2: begin
          b = {~a[31], a[30:25], a[24:0] ^ 25'($urandom_range(0, 15))};
        end
        default: begin
          ea = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(59, 62));
          a[30:25] = 6'(ea);
          b[30:25] = 6'(ea - int'($urandom_range(0, 1)));
        end
      endcase
      r = ref_add(a, b);
      run_check("rand", a, b, r[31:0], r[35:32]);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

`default_nettype wire
